// File: rtl/neuron_lut_loader_if.sv
// Handshake bundle for neuron_lut_loader: table load path and lookup path.
interface neuron_lut_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
);
  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_done;
  logic              cfg_err;
  logic              in_valid;
  logic [ADDR_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    output in_valid, in_data,
    input  cfg_ready, cfg_done, cfg_err,
    input  out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    input  in_valid, in_data,
    output cfg_ready, cfg_done, cfg_err,
    output out_valid, out_data
  );
endinterface

// File: rtl/neuron_lut_loader.sv
// Streamed LUT loader with digit-reversed write order and
// single-cycle registered lookups.
module neuron_lut_loader #(
  parameter int ADDR_W  = 8,
  parameter int DIGIT_W = 2,
  parameter int DATA_W  = 2
) (
  input logic clk,
  input logic rst_n,
  neuron_lut_loader_if.slave bus
);
  localparam int ND = ADDR_W / DIGIT_W;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_k;
  logic [ADDR_W-1:0]   w_k_next;
  logic [ADDR_W-1:0]   w_waddr;
  logic                w_wr;
  logic                w_err;
  logic                w_lk;
  logic                r_err;
  logic                r_ov;
  logic [DATA_W-1:0]   r_od;
  logic [DATA_W-1:0]   r_tab [2**ADDR_W];

  // Beat k lands at k with its base-4 digits reversed.
  always_comb begin
    w_waddr = '0;
    for (int i = 0; i < ND; i++) begin
      w_waddr[i*DIGIT_W +: DIGIT_W] =
        r_k[(ND-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    w_wr     = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      S_EMPTY, S_READY: begin
        if (bus.cfg_start) begin
          w_next   = S_LOAD;
          w_k_next = '0;
        end
      end
      S_LOAD: begin
        if (bus.cfg_start) begin
          w_k_next = '0;
          w_err    = 1'b1;
        end else if (bus.cfg_valid) begin
          w_wr     = 1'b1;
          w_k_next = ADDR_W'(r_k + 1'b1);
          if (r_k == '1) w_next = S_READY;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  assign w_lk = bus.in_valid && (r_state == S_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_k     <= '0;
      r_err   <= 1'b0;
      r_ov    <= 1'b0;
      r_od    <= '0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      r_err   <= w_err;
      r_ov    <= w_lk;
      if (w_lk) r_od <= r_tab[bus.in_data];
    end
  end

  // Table storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_tab[w_waddr] <= bus.cfg_data;
  end

  assign bus.cfg_ready = (r_state == S_LOAD);
  assign bus.cfg_done  = (r_state == S_READY);
  assign bus.cfg_err   = r_err;
  assign bus.out_valid = r_ov;
  assign bus.out_data  = r_od;
endmodule
